// File: rtl/usb_ep_dma_pkg.sv
// Shared definitions for the USB endpoint-buffer DMA initiator: EP buffer
// geometry, Wishbone slot address width and the FSM state type.
package usb_ep_dma_pkg;

    localparam int USB_EP_AW   = 9;
    localparam int USB_WORD_W  = 32;
    localparam int USB_WB_AW   = 12;
    localparam int USB_RAM_AW  = 15;
    localparam int USB_LEN_W   = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RAM_RD = 3'd1,
        ST_WB_REQ = 3'd2,
        ST_RAM_WR = 3'd3,
        ST_DONE   = 3'd4
    } dma_state_e;

endpackage

// File: rtl/usb_ep_dma.sv
// Wishbone initiator copying 32-bit words between the USB EP buffer window and
// a local single-port RAM; one command per packet, done pulse plus word count.
module usb_ep_dma
    import usb_ep_dma_pkg::*;
#(
    parameter int EP_AW  = USB_EP_AW,
    parameter int RAM_AW = USB_RAM_AW,
    parameter int LEN_W  = USB_LEN_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_dir,
    input  logic [EP_AW-1:0]      cmd_ep_addr,
    input  logic [RAM_AW-1:0]     cmd_ram_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  done_aborted,
    output logic [LEN_W-1:0]      xfer_cnt,
    output logic [USB_WB_AW-1:0]  wb_addr,
    output logic [USB_WORD_W-1:0] wb_wdata,
    input  logic [USB_WORD_W-1:0] wb_rdata,
    output logic                  wb_we,
    output logic                  wb_cyc,
    input  logic                  wb_ack,
    output logic [RAM_AW-1:0]     ram_addr,
    output logic [USB_WORD_W-1:0] ram_wdata,
    output logic                  ram_we,
    output logic                  ram_re,
    input  logic [USB_WORD_W-1:0] ram_rdata
);

    dma_state_e state_r;
    dma_state_e state_nxt_s;

    logic                  dir_r;
    logic [EP_AW-1:0]      ep_addr_r;
    logic [RAM_AW-1:0]     ram_addr_r;
    logic [LEN_W-1:0]      len_r;
    logic [LEN_W-1:0]      xfer_cnt_r;
    logic                  abort_seen_r;
    logic                  rd_pend_r;
    logic                  wb_cyc_r;
    logic                  wb_we_r;
    logic                  ram_we_r;
    logic                  ram_re_r;
    logic                  done_r;
    logic                  done_aborted_r;
    logic                  busy_r;
    logic                  cmd_ready_r;
    logic [USB_WORD_W-1:0] wb_wdata_r;
    logic [USB_WORD_W-1:0] ram_wdata_r;

    logic                  accept_s;
    logic                  boundary_s;
    logic                  last_s;
    logic                  stop_s;
    logic                  cyc_dir_s;

    // Next-state decode and word-boundary decision.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        boundary_s  = 1'b0;
        last_s      = ((xfer_cnt_r + {{(LEN_W-1){1'b0}}, 1'b1}) == len_r);
        // Abort seen in the boundary cycle itself counts as well.
        stop_s      = last_s | abort_seen_r | abort;
        cyc_dir_s   = dir_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept_s  = 1'b1;
                    cyc_dir_s = cmd_dir;
                    if (cmd_len == {LEN_W{1'b0}}) begin
                        state_nxt_s = ST_DONE;
                    end else if (cmd_dir) begin
                        state_nxt_s = ST_RAM_RD;
                    end else begin
                        state_nxt_s = ST_WB_REQ;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RAM_RD: begin
                state_nxt_s = ST_WB_REQ;
            end
            ST_WB_REQ: begin
                if (wb_ack) begin
                    if (dir_r) begin
                        boundary_s  = 1'b1;
                        state_nxt_s = stop_s ? ST_DONE : ST_RAM_RD;
                    end else begin
                        state_nxt_s = ST_RAM_WR;
                    end
                end else begin
                    state_nxt_s = ST_WB_REQ;
                end
            end
            ST_RAM_WR: begin
                boundary_s  = 1'b1;
                state_nxt_s = stop_s ? ST_DONE : ST_WB_REQ;
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Bus and handshake strobes, registered from the next state so wb_cyc
    // drops on the ack edge and is never high in the cycle after an ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_cyc_r    <= 1'b0;
            wb_we_r     <= 1'b0;
            ram_re_r    <= 1'b0;
            ram_we_r    <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
            rd_pend_r   <= 1'b0;
        end else begin
            wb_cyc_r    <= (state_nxt_s == ST_WB_REQ);
            wb_we_r     <= (state_nxt_s == ST_WB_REQ) && cyc_dir_s;
            ram_re_r    <= (state_nxt_s == ST_RAM_RD);
            ram_we_r    <= (state_nxt_s == ST_RAM_WR);
            done_r      <= (state_nxt_s == ST_DONE);
            busy_r      <= (state_nxt_s != ST_IDLE);
            cmd_ready_r <= (state_nxt_s == ST_IDLE);
            rd_pend_r   <= ram_re_r;
        end
    end

    // Command latch, address/length counters, sticky abort and abort status.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_r          <= 1'b0;
            ep_addr_r      <= {EP_AW{1'b0}};
            ram_addr_r     <= {RAM_AW{1'b0}};
            len_r          <= {LEN_W{1'b0}};
            xfer_cnt_r     <= {LEN_W{1'b0}};
            abort_seen_r   <= 1'b0;
            done_aborted_r <= 1'b0;
        end else if (accept_s) begin
            dir_r          <= cmd_dir;
            ep_addr_r      <= cmd_ep_addr;
            ram_addr_r     <= cmd_ram_addr;
            len_r          <= cmd_len;
            xfer_cnt_r     <= {LEN_W{1'b0}};
            abort_seen_r   <= 1'b0;
            done_aborted_r <= 1'b0;
        end else if (boundary_s) begin
            xfer_cnt_r   <= xfer_cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
            ep_addr_r    <= ep_addr_r + {{(EP_AW-1){1'b0}}, 1'b1};
            ram_addr_r   <= ram_addr_r + {{(RAM_AW-1){1'b0}}, 1'b1};
            abort_seen_r <= 1'b0;
            if (stop_s && !last_s) begin
                done_aborted_r <= 1'b1;
            end else begin
                done_aborted_r <= done_aborted_r;
            end
        end else if ((state_r != ST_IDLE) && abort) begin
            abort_seen_r <= 1'b1;
        end else begin
            abort_seen_r <= abort_seen_r;
        end
    end

    // Data capture: RAM word one cycle after the read strobe, EP word on ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_wdata_r  <= {USB_WORD_W{1'b0}};
            ram_wdata_r <= {USB_WORD_W{1'b0}};
        end else begin
            if (rd_pend_r) begin
                wb_wdata_r <= ram_rdata;
            end else begin
                wb_wdata_r <= wb_wdata_r;
            end
            if ((state_r == ST_WB_REQ) && wb_ack && !dir_r) begin
                ram_wdata_r <= wb_rdata;
            end else begin
                ram_wdata_r <= ram_wdata_r;
            end
        end
    end

    assign cmd_ready    = cmd_ready_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign done_aborted = done_aborted_r;
    assign xfer_cnt     = xfer_cnt_r;
    assign wb_addr      = USB_WB_AW'(ep_addr_r);
    assign wb_wdata     = wb_wdata_r;
    assign wb_we        = wb_we_r;
    assign wb_cyc       = wb_cyc_r;
    assign ram_addr     = ram_addr_r;
    assign ram_wdata    = ram_wdata_r;
    assign ram_we       = ram_we_r;
    assign ram_re       = ram_re_r;

endmodule
